// File: rtl/isa_pkg.sv
// Shared ISA definitions: the opcode constants, the default reset PC,
// the fetch state encoding, and small helpers used by fetch and control.
package isa_pkg;

    localparam logic [4:0]  OP_HALT          = 5'b00000;
    localparam logic [4:0]  OP_NOP           = 5'b00001;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    localparam logic [15:0] NOP_INST         = {OP_NOP, 11'b0};

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    // Instruction addresses are 16-bit word aligned; bit 0 is always zero.
    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its +2 incrementer.
// A redirect load has priority over a sequential advance.
module pc_reg
    import isa_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_pc,
    input  logic        advance,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2
);

    // The increment wraps naturally at 16 bits: 16'hFFFE + 2 = 16'h0000.
    assign pc_plus2 = pc + 16'd2;

    // PC state: reset, redirect load, or step to the next word.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= align_pc(RESET_PC);
        end else if (load) begin
            pc <= align_pc(load_pc);
        end else if (advance) begin
            pc <= pc_plus2;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction
// memory, holds it for decode until accepted, follows redirects and stops
// on a HALT opcode.
// Optional build macro FETCH_PERF_EN adds a saturating transfer counter
// on port perf_fetch_cnt.
module fetch_unit
    import isa_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst,
    output logic [15:0] pc_inc,
    output logic        halted,
`ifdef FETCH_PERF_EN
    output logic        err,
    output logic [15:0] perf_fetch_cnt
`else
    output logic        err
`endif
);

    fetch_state_e state, next_state;

    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        active;       // REQ or HOLD: redirects are honoured
    logic        take_redirect;
    logic        transfer;
    logic        capture;
    logic        halt_xfer;

    assign active        = (state == ST_REQ) || (state == ST_HOLD);
    assign take_redirect = active && redirect;
    assign transfer      = (state == ST_HOLD) && inst_ready;
    assign halt_xfer     = transfer && is_halt(inst);
    // A response arriving together with a redirect belongs to the old path.
    assign capture       = (state == ST_REQ) && imem_ack && !redirect;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (take_redirect),
        .load_pc  (redirect_pc),
        .advance  (transfer && !halt_xfer),
        .pc       (pc),
        .pc_plus2 (pc_plus2)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_REQ;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; a HALT transfer wins even over a coincident redirect.
    // NOTE: next_state gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_REQ: begin
                if (redirect)      next_state = ST_REQ;
                else if (imem_ack) next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (halt_xfer)                 next_state = ST_HALTED;
                else if (transfer || redirect) next_state = ST_REQ;
            end
            ST_HALTED: next_state = ST_HALTED;
            default:   next_state = ST_REQ;
        endcase
    end

    // FSM outputs, decoded purely from the current state.
    always_comb begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        halted     = 1'b0;
        unique case (state)
            ST_REQ:    imem_req   = 1'b1;
            ST_HOLD:   inst_valid = 1'b1;
            ST_HALTED: halted     = 1'b1;
            default:   imem_req   = 1'b0;
        endcase
    end

    assign imem_addr = pc;

    // Instruction holding register: loaded only by a response to the live request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst   <= NOP_INST;
            pc_inc <= 16'h0000;
        end else if (capture) begin
            inst   <= imem_rdata;
            pc_inc <= pc_plus2;
        end
    end

    // Sticky flag for a redirect target with bit 0 set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (take_redirect && redirect_pc[0]) begin
            err <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating count of instructions handed to decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 16'h0000;
        end else if (transfer && (perf_fetch_cnt != 16'hFFFF)) begin
            perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
        end
    end
`endif

endmodule
